// File: rtl/wb_uart_if.sv
// Wishbone classic bus bundle with a 16-bit address and 16-bit data.
// The master drives cyc/stb/we/adr/dat_m, and the slave returns dat_s/ack.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_m, input  dat_s, ack);
    modport slave  (input  cyc, stb, we, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/wb_uart.sv
// Wishbone byte console: TX FIFO into an 8N1 transmitter, and an 8N1 receiver with one holding register.
// Every bus access acks after exactly one wait state; a DATA write into a full FIFO with no pop is dropped.
module wb_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 4
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    if_wb.slave  wb,
    output logic tx_o,
    input  logic rx_i
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   FULL = (PW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        r_ack;
    logic [15:0] r_dat_s;
    logic [15:0] w_rdata;
    logic w_req, w_wr, w_rd, w_sel_data, w_sel_stat;
    logic w_push_req, w_rd_data, w_rd_stat;
    logic w_unused;

    assign w_req      = wb.cyc & wb.stb & ~r_ack;
    assign w_wr       = w_req & wb.we;
    assign w_rd       = w_req & ~wb.we;
    assign w_sel_data = (wb.adr[2:1] == 2'd0);
    assign w_sel_stat = (wb.adr[2:1] == 2'd1);
    assign w_push_req = w_wr & w_sel_data;
    assign w_rd_data  = w_rd & w_sel_data;
    assign w_rd_stat  = w_rd & w_sel_stat;
    assign w_unused   = ^{wb.adr[15:3], wb.adr[0], wb.dat_m[15:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    r_mem [TX_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic w_empty, w_full, w_pop, w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL);
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign w_push  = w_push_req & (~w_full | w_pop);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= wb.dat_m[7:0];
    end

    // ---------------- TX FSM ----------------
    state_t        r_tx_state, w_tx_nstate;
    logic [CW-1:0] r_tx_cnt, w_tx_ncnt;
    logic [2:0]    r_tx_bit, w_tx_nbit;
    logic [7:0]    r_tx_shift, w_tx_nshift;
    logic          r_tx_o, w_tx_line;

    always_comb begin
        w_tx_nstate = r_tx_state;
        w_tx_ncnt   = r_tx_cnt;
        w_tx_nbit   = r_tx_bit;
        w_tx_nshift = r_tx_shift;
        w_pop       = 1'b0;
        w_tx_line   = 1'b1;
        case (r_tx_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_tx_nshift = r_mem[r_rd_ptr];
                    w_tx_ncnt   = '0;
                    w_tx_nbit   = '0;
                    w_tx_nstate = S_START;
                end
            end
            S_START: begin
                w_tx_line = 1'b0;
                if (r_tx_cnt == LAST) begin
                    w_tx_ncnt   = '0;
                    w_tx_nstate = S_DATA;
                end else begin
                    w_tx_ncnt = r_tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (r_tx_cnt == LAST) begin
                    w_tx_ncnt   = '0;
                    w_tx_nshift = {1'b0, r_tx_shift[7:1]};
                    w_tx_nbit   = r_tx_bit + 1'b1;
                    if (r_tx_bit == 3'd7) w_tx_nstate = S_STOP;
                end else begin
                    w_tx_ncnt = r_tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_ncnt   = '0;
                    w_tx_nstate = S_IDLE;
                end else begin
                    w_tx_ncnt = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_o     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_nstate;
            r_tx_cnt   <= w_tx_ncnt;
            r_tx_bit   <= w_tx_nbit;
            r_tx_shift <= w_tx_nshift;
            r_tx_o     <= w_tx_line;
        end
    end

    // ---------------- RX path ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    state_t        r_rx_state, w_rx_nstate;
    logic [CW-1:0] r_rx_cnt, w_rx_ncnt;
    logic [2:0]    r_rx_bit, w_rx_nbit;
    logic [7:0]    r_rx_shift, w_rx_nshift;
    logic          w_rx_ok, w_rx_ferr;
    logic [7:0]    r_rx_hold;
    logic          r_rx_valid, r_rx_overrun, r_rx_ferr;

    always_comb begin
        w_rx_nstate = r_rx_state;
        w_rx_ncnt   = r_rx_cnt;
        w_rx_nbit   = r_rx_bit;
        w_rx_nshift = r_rx_shift;
        w_rx_ok     = 1'b0;
        w_rx_ferr   = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_ncnt   = '0;
                    w_rx_nbit   = '0;
                    w_rx_nstate = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF) begin
                    w_rx_ncnt   = '0;
                    w_rx_nstate = r_rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    w_rx_ncnt = r_rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == LAST) begin
                    w_rx_ncnt   = '0;
                    w_rx_nshift = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_nbit   = r_rx_bit + 1'b1;
                    if (r_rx_bit == 3'd7) w_rx_nstate = S_STOP;
                end else begin
                    w_rx_ncnt = r_rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == LAST) begin
                    w_rx_ncnt   = '0;
                    w_rx_ok     = r_rx_s2;
                    w_rx_ferr   = ~r_rx_s2;
                    w_rx_nstate = S_IDLE;
                end else begin
                    w_rx_ncnt = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_nstate;
            r_rx_cnt   <= w_rx_ncnt;
            r_rx_bit   <= w_rx_nbit;
            r_rx_shift <= w_rx_nshift;
        end
    end

    // Flag sets take priority over clears from a coincident bus read.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_rx_hold    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            if (w_rx_ok && (!r_rx_valid || w_rd_data)) r_rx_hold <= r_rx_shift;
            if (w_rx_ok)        r_rx_valid <= 1'b1;
            else if (w_rd_data) r_rx_valid <= 1'b0;
            if (w_rx_ok && r_rx_valid && !w_rd_data) r_rx_overrun <= 1'b1;
            else if (w_rd_stat)                      r_rx_overrun <= 1'b0;
            if (w_rx_ferr)      r_rx_ferr <= 1'b1;
            else if (w_rd_stat) r_rx_ferr <= 1'b0;
        end
    end

    // ---------------- Bus read/ack ----------------
    always_comb begin
        w_rdata = '0;
        case (wb.adr[2:1])
            2'd0:    w_rdata = {8'h00, r_rx_hold};
            2'd1:    w_rdata = {11'd0, r_rx_ferr, r_rx_overrun, r_rx_valid,
                                w_empty & (r_tx_state == S_IDLE), w_full};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_ack   <= 1'b0;
            r_dat_s <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_s <= w_rd ? w_rdata : 16'h0000;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.dat_s = r_dat_s;
    assign tx_o     = r_tx_o;
endmodule

// File: tb/tb_wb_uart.sv
// Directed bench for wb_uart: TX frames are checked against a byte queue, bus reads against expected words.
module tb_wb_uart;
    localparam int CPB = 8;

    logic sys_clk_i = 1'b0;
    logic sys_rst_i = 1'b1;
    logic rx_i      = 1'b1;
    logic tx_o;

    if_wb wb_bus ();

    wb_uart #(.CLKS_PER_BIT(CPB), .TX_DEPTH(4)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .wb        (wb_bus),
        .tx_o      (tx_o),
        .rx_i      (rx_i)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int errors = 0;
    int checks = 0;
    logic [7:0]  tx_q [$];
    logic [15:0] rd_q [$];
    bit mon_en = 1'b1;
    bit b2b    = 1'b0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; checks ack is low, then high for one cycle, then low with dat_s back at 0.
    task automatic bus(input logic w, input logic [15:0] a, input logic [15:0] d, output logic [15:0] q);
        logic a0, a1, a2;
        logic [15:0] d2;
        @(posedge sys_clk_i); #1;
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = w; wb_bus.adr = a; wb_bus.dat_m = d;
        @(negedge sys_clk_i); a0 = wb_bus.ack;
        @(negedge sys_clk_i); a1 = wb_bus.ack; q = wb_bus.dat_s;
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
        @(negedge sys_clk_i); a2 = wb_bus.ack; d2 = wb_bus.dat_s;
        chk("ack_shape", 80'({a0, a1, a2, d2}), 80'({3'b010, 16'h0000}));
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] q;
        bus(1'b1, a, d, q);
    endtask

    task automatic rd_expect(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] q;
        rd_q.push_back(exp);
        bus(1'b0, a, 16'h0000, q);
        chk(tag, 80'(q), 80'(rd_q.pop_front()));
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            repeat (CPB) @(posedge sys_clk_i);
            #1;
        end
        rx_i = 1'b1;
    endtask

    // TX monitor: each frame is sampled every cycle and compared with the ideal 8N1 waveform.
    initial begin : tx_mon
        logic [79:0] wave, expw;
        logic [9:0]  f;
        logic        g0, g1;
        bit          pend;
        pend = 1'b0;
        forever begin
            if (!pend) @(negedge sys_clk_i);
            pend = 1'b0;
            if (mon_en && tx_o === 1'b0) begin
                if (tx_q.size() > 0) f = {1'b1, tx_q.pop_front(), 1'b0};
                else                 f = 10'h3FF;
                wave[0] = tx_o;
                for (int k = 1; k < 80; k++) begin
                    @(negedge sys_clk_i);
                    wave[k] = tx_o;
                end
                for (int k = 0; k < 80; k++) expw[k] = f[k / CPB];
                chk("tx_frame", wave, expw);
                if (b2b && tx_q.size() > 0) begin
                    @(negedge sys_clk_i); g0 = tx_o;
                    @(negedge sys_clk_i); g1 = tx_o;
                    chk("tx_gap", 80'({g0, g1}), 80'(2'b10));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic t0, t1;
        int lows;
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
        wb_bus.adr = '0;   wb_bus.dat_m = '0;

        // Reset state
        repeat (4) @(posedge sys_clk_i);
        #1 sys_rst_i = 1'b0;
        @(negedge sys_clk_i);
        chk("reset_outputs", 80'({tx_o, wb_bus.ack, wb_bus.dat_s}), 80'({1'b1, 1'b0, 16'h0000}));
        rd_expect("status_reset", 16'h0002, 16'h0002);
        rd_expect("unused_reg", 16'h0004, 16'h0000);

        // Single frame: 0x55 with junk in the upper byte
        tx_q.push_back(8'h55);
        wr(16'h0000, 16'hAB55);
        t0 = tx_o;
        @(negedge sys_clk_i); t1 = tx_o;
        chk("tx_start_latency", 80'({t0, t1}), 80'(2'b10));
        repeat (20) @(posedge sys_clk_i);
        rd_expect("status_busy", 16'h0002, 16'h0000);
        repeat (80) @(negedge sys_clk_i);
        chk("tx_q_drained1", 80'(tx_q.size()), 80'(0));
        rd_expect("status_idle", 16'h0002, 16'h0002);

        // Six back-to-back writes: the sixth finds the FIFO full and is dropped
        b2b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) tx_q.push_back(8'(i));
            wr(16'h0000, 16'(i));
        end
        rd_expect("status_full", 16'h0002, 16'h0001);
        repeat (5 * 81 + 60) @(negedge sys_clk_i);
        chk("tx_q_drained5", 80'(tx_q.size()), 80'(0));
        b2b = 1'b0;
        rd_expect("status_idle5", 16'h0002, 16'h0002);

        // RX: good byte, read, then overrun
        send_rx(8'hC3, 1'b1);
        repeat (4) @(posedge sys_clk_i);
        rd_expect("rx_status", 16'h0002, 16'h0006);
        rd_expect("rx_data", 16'h0000, 16'h00C3);
        rd_expect("rx_status_clr", 16'h0002, 16'h0002);
        send_rx(8'hC3, 1'b1);
        send_rx(8'h5A, 1'b1);
        repeat (4) @(posedge sys_clk_i);
        rd_expect("rx_overrun", 16'h0002, 16'h000E);
        rd_expect("rx_data_keep", 16'h0000, 16'h00C3);
        rd_expect("rx_status_after", 16'h0002, 16'h0002);

        // RX: framing error, then a short glitch
        send_rx(8'hA5, 1'b0);
        repeat (4) @(posedge sys_clk_i);
        rd_expect("rx_frame_err", 16'h0002, 16'h0012);
        rd_expect("rx_frame_err_clr", 16'h0002, 16'h0002);
        @(posedge sys_clk_i); #1 rx_i = 1'b0;
        repeat (2) @(posedge sys_clk_i);
        #1 rx_i = 1'b1;
        repeat (100) @(posedge sys_clk_i);
        rd_expect("rx_glitch_status", 16'h0002, 16'h0002);
        rd_expect("rx_glitch_hold", 16'h0000, 16'h00C3);

        // Reset in the middle of a frame with three bytes queued
        mon_en = 1'b0;
        wr(16'h0000, 16'h0000);
        wr(16'h0000, 16'h0022);
        wr(16'h0000, 16'h0033);
        wr(16'h0000, 16'h0044);
        repeat (30) @(negedge sys_clk_i);
        chk("tx_busy_pre_rst", 80'(tx_o), 80'(1'b0));
        @(posedge sys_clk_i); #1 sys_rst_i = 1'b1;
        @(negedge sys_clk_i);
        @(negedge sys_clk_i);
        chk("rst_tx_next", 80'({tx_o, wb_bus.ack}), 80'(2'b10));
        sys_rst_i = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk_i);
            if (tx_o !== 1'b1) lows++;
        end
        chk("no_frames_after_rst", 80'(lows), 80'(0));
        rd_expect("status_after_rst", 16'h0002, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
